input_event_logger: RTL and testbench

Captures value changes on a parametrised number of controller input channels (joystick, analog, paddle, spinner, mouse words) and queues each change as a timestamped event in a FIFO for the test CPU to read. It sits in `system` between the hps_io-sourced input buses and the CPU register map. It generalises the static per-frame input snapshot to N channels of arbitrary width, adding change coalescing, round-robin arbitration and overflow accounting.

---
 rtl/input_event_logger_if.sv | 34 +++
 rtl/input_event_logger.sv | 172 +++++++++++++++++
 tb/tb_input_event_logger.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/input_event_logger_if.sv
// Event-logger bus: sampling controls and input words in, show-ahead event FIFO head out.
// Latency: none (wires only).
// Backpressure: the consumer pops with rd; the logger holds the head entry until then.
interface input_event_logger_if #(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 33
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  logic                      enable;
  logic                      clear;
  logic [CHANNELS*WIDTH-1:0] inputs;
  logic [TS_WIDTH-1:0]       timestamp;
  logic                      rd;
  logic                      ev_valid;
  logic [CW-1:0]             ev_channel;
  logic [WIDTH-1:0]          ev_value;
  logic [TS_WIDTH-1:0]       ev_time;
  logic [NW-1:0]             ev_count;
  logic [7:0]                merged;

  modport master (
    output enable, clear, inputs, timestamp, rd,
    input  ev_valid, ev_channel, ev_value, ev_time, ev_count, merged
  );

  modport slave (
    input  enable, clear, inputs, timestamp, rd,
    output ev_valid, ev_channel, ev_value, ev_time, ev_count, merged
  );
endinterface

// File: rtl/input_event_logger.sv
// Logs value changes on N input channels as timestamped events in a show-ahead FIFO.
// Latency: change sampled at edge k is pending at k, pushed at k+1, visible after k+1.
// Backpressure: a full FIFO stalls the arbiter; further changes coalesce and count in merged.
module input_event_logger #(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 33
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input_event_logger_if.slave  bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = CW + WIDTH + TS_WIDTH;

  localparam logic [0:0] PRIME = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [WIDTH-1:0]    in_ch      [CHANNELS];
  logic [WIDTH-1:0]    prev_q     [CHANNELS];
  logic [WIDTH-1:0]    snap_val_q [CHANNELS];
  logic [TS_WIDTH-1:0] snap_ts_q  [CHANNELS];
  logic [CHANNELS-1:0] chg, pend_q, pend_d;
  logic [CW-1:0]       rr_q, rr_d, gnt_ch;
  logic                gnt_found, grant, pop, full;
  logic [7:0]          merged_q, merged_d;
  logic [EW-1:0]       mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]       count_q, count_d;
  logic [EW-1:0]       head;

  // Split the flat bus into channel words and flag channels that moved since the last sample.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      in_ch[i] = bus.inputs[i*WIDTH +: WIDTH];
      chg[i]   = bus.enable && (state_q == RUN) && (in_ch[i] != prev_q[i]);
    end
  end

  // Round-robin: first pending channel at or after rr, wrapping.
  always_comb begin
    int sum;
    sum       = 0;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    for (int off = 0; off < CHANNELS; off++) begin
      sum = int'(rr_q) + off;
      if (sum >= CHANNELS) sum = sum - CHANNELS;
      if (!gnt_found && pend_q[sum[CW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_ch    = sum[CW-1:0];
      end
    end
  end

  assign full  = (count_q == NW'(DEPTH));
  assign pop   = bus.rd && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
  assign grant = gnt_found && (!full || pop);

  // Pending flags, merge count, rr pointer and FSM next state; clear overrides everything.
  always_comb begin
    int merges;
    int tot;
    merges  = 0;
    tot     = 0;
    pend_d  = pend_q;
    rr_d    = rr_q;
    state_d = state_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chg[i]) begin
        // A new change beats the grant's clear; the push still takes the old snapshot.
        pend_d[i] = 1'b1;
        if (pend_q[i] && !(grant && (gnt_ch == CW'(i)))) merges = merges + 1;
      end else if (grant && (gnt_ch == CW'(i))) begin
        pend_d[i] = 1'b0;
      end
    end
    tot      = int'(merged_q) + merges;
    merged_d = (tot > 255) ? 8'hFF : tot[7:0];
    if (grant) rr_d = (int'(gnt_ch) == CHANNELS - 1) ? '0 : gnt_ch + CW'(1);
    if (bus.enable && (state_q == PRIME)) state_d = RUN;
    if (bus.clear) begin
      pend_d   = '0;
      merged_d = '0;
      rr_d     = '0;
      state_d  = PRIME;
    end
  end

  // FIFO occupancy next state.
  always_comb begin
    count_d = count_q;
    if (bus.clear) begin
      count_d = '0;
    end else if (grant && !pop) begin
      count_d = count_q + NW'(1);
    end else if (pop && !grant) begin
      count_d = count_q - NW'(1);
    end
  end

  // Control registers and the previous-sample shadow of every channel.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= PRIME;
      pend_q   <= '0;
      rr_q     <= '0;
      merged_q <= '0;
      for (int i = 0; i < CHANNELS; i++) prev_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      rr_q     <= rr_d;
      merged_q <= merged_d;
      if (bus.enable) begin
        for (int i = 0; i < CHANNELS; i++) prev_q[i] <= in_ch[i];
      end
    end
  end

  // Per-channel snapshot: latest value and time win.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        snap_val_q[i] <= '0;
        snap_ts_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (chg[i] && !bus.clear) begin
          snap_val_q[i] <= in_ch[i];
          snap_ts_q[i]  <= bus.timestamp;
        end
      end
    end
  end

  // Event FIFO storage and pointers; storage is reset so an empty head reads as zero.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (bus.clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (grant) begin
          mem_q[wr_ptr_q] <= {gnt_ch, snap_val_q[gnt_ch], snap_ts_q[gnt_ch]};
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.ev_valid   = (count_q != '0);
  assign bus.ev_channel = head[EW-1 -: CW];
  assign bus.ev_value   = head[TS_WIDTH +: WIDTH];
  assign bus.ev_time    = head[TS_WIDTH-1:0];
  assign bus.ev_count   = count_q;
  assign bus.merged     = merged_q;
endmodule

// File: tb/tb_input_event_logger.sv
// Bench for input_event_logger: table-driven change vectors with an event scoreboard,
// plus hand sequences for coalescing, full-with-pop, clear and async reset.
module tb_input_event_logger;
  localparam int CH  = 6;
  localparam int W   = 32;
  localparam int TSW = 33;
  localparam int CW  = 3;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  input_event_logger_if #(.CHANNELS(CH), .WIDTH(W), .DEPTH(16), .TS_WIDTH(TSW)) a_if ();
  input_event_logger_if #(.CHANNELS(CH), .WIDTH(W), .DEPTH(2),  .TS_WIDTH(TSW)) b_if ();

  input_event_logger #(.CHANNELS(CH), .WIDTH(W), .DEPTH(16), .TS_WIDTH(TSW)) dut (
    .clk_sys(clk_sys), .reset(reset), .bus(a_if));
  input_event_logger #(.CHANNELS(CH), .WIDTH(W), .DEPTH(2), .TS_WIDTH(TSW)) dut2 (
    .clk_sys(clk_sys), .reset(reset), .bus(b_if));

  typedef struct {
    logic [CW-1:0]  ch;
    logic [W-1:0]   val;
    logic [TSW-1:0] ts;
  } ev_t;

  typedef struct {
    logic [CH*W-1:0] word;
    logic [TSW-1:0]  ts;
    int              exp_n;
  } vec_t;

  ev_t             sb[$];
  vec_t            tbl[5];
  logic [CH*W-1:0] shadow;
  int              rr_m;
  int              n_cmp = 0;
  int              n_bad = 0;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] set_ch(input logic [CH*W-1:0] w, input int ch,
                                            input logic [W-1:0] v);
    logic [CH*W-1:0] r;
    r = w;
    r[ch*W +: W] = v;
    return r;
  endfunction

  // Drive one enable cycle on dut; expected events go to the scoreboard in round-robin order.
  task automatic apply_vec(input logic [CH*W-1:0] w, input logic [TSW-1:0] ts);
    int last;
    last = -1;
    for (int k = 0; k < CH; k++) begin
      int c;
      ev_t e;
      c = (rr_m + k) % CH;
      if (w[c*W +: W] !== shadow[c*W +: W]) begin
        e.ch  = c[CW-1:0];
        e.val = w[c*W +: W];
        e.ts  = ts;
        sb.push_back(e);
        last = c;
      end
    end
    if (last >= 0) rr_m = (last + 1) % CH;
    shadow         = w;
    a_if.inputs    = w;
    a_if.timestamp = ts;
    a_if.enable    = 1'b1;
    tick();
    a_if.enable    = 1'b0;
  endtask

  // Pop every expected event from dut, comparing the head against the scoreboard.
  task automatic drain(input string tag);
    while (sb.size() > 0) begin
      ev_t e;
      int  t;
      e = sb.pop_front();
      t = 0;
      while (!a_if.ev_valid && t < 10) begin
        tick();
        t++;
      end
      if (!a_if.ev_valid) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: ev_valid=0, expected 1", tag);
      end else begin
        check({tag, "_ch"},  64'(a_if.ev_channel), 64'(e.ch));
        check({tag, "_val"}, 64'(a_if.ev_value),   64'(e.val));
        check({tag, "_ts"},  64'(a_if.ev_time),    64'(e.ts));
        a_if.rd = 1'b1;
        tick();
        a_if.rd = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH*W-1:0] w;
    reset = 1'b1;
    a_if.enable = 1'b0; a_if.clear = 1'b0; a_if.rd = 1'b0; a_if.inputs = '0; a_if.timestamp = '0;
    b_if.enable = 1'b0; b_if.clear = 1'b0; b_if.rd = 1'b0; b_if.inputs = '0; b_if.timestamp = '0;
    shadow = '0;
    rr_m   = 0;
    #1;
    check("rst_valid",  64'(a_if.ev_valid),   64'd0);
    check("rst_count",  64'(a_if.ev_count),   64'd0);
    check("rst_merged", 64'(a_if.merged),     64'd0);
    check("rst_chan",   64'(a_if.ev_channel), 64'd0);
    check("rst_value",  64'(a_if.ev_value),   64'd0);
    check("rst_time",   64'(a_if.ev_time),    64'd0);
    tick();
    tick();
    reset = 1'b0;

    // Prime both instances: first enable only loads the shadow.
    w = set_ch('0, 0, 32'h12);
    a_if.inputs = w; a_if.timestamp = 33'd5; a_if.enable = 1'b1;
    b_if.enable = 1'b1;
    tick();
    a_if.enable = 1'b0; b_if.enable = 1'b0;
    shadow = w;
    tick();
    tick();
    check("prime_valid", 64'(a_if.ev_valid), 64'd0);
    check("prime_count", 64'(a_if.ev_count), 64'd0);

    w = set_ch(w, 0, 32'hA0); w = set_ch(w, 3, 32'h33); w = set_ch(w, 5, 32'h55);
    tbl[0] = '{word: w, ts: 33'd200, exp_n: 3};
    w = set_ch(w, 2, 32'h10);
    tbl[1] = '{word: w, ts: 33'd100, exp_n: 1};
    for (int c = 0; c < CH; c++) w = set_ch(w, c, 32'h100 + c);
    tbl[2] = '{word: w, ts: 33'd300, exp_n: 6};
    tbl[3] = '{word: w, ts: 33'd400, exp_n: 0};
    w = set_ch(w, 1, 32'h80000101); w = set_ch(w, 4, 32'h0);
    tbl[4] = '{word: w, ts: 33'h1_0000_0001, exp_n: 2};

    for (int i = 0; i < 5; i++) begin
      apply_vec(tbl[i].word, tbl[i].ts);
      check($sformatf("v%0d_lat", i), 64'(a_if.ev_count), 64'd0);
      repeat (tbl[i].exp_n) tick();
      check($sformatf("v%0d_count", i), 64'(a_if.ev_count), 64'(tbl[i].exp_n));
      drain($sformatf("v%0d", i));
      check($sformatf("v%0d_empty", i), 64'(a_if.ev_valid), 64'd0);
    end

    // Coalescing on the 2-deep instance: channel 1 takes values 1..4 on consecutive samples.
    for (int v = 1; v <= 4; v++) begin
      b_if.inputs    = set_ch('0, 1, W'(v));
      b_if.timestamp = TSW'(9 + v);
      b_if.enable    = 1'b1;
      tick();
    end
    b_if.enable = 1'b0;
    check("coal_count",  64'(b_if.ev_count), 64'd2);
    check("coal_merged", 64'(b_if.merged),   64'd1);
    check("coal_head1",  64'(b_if.ev_value), 64'd1);
    check("coal_time1",  64'(b_if.ev_time),  64'd10);
    b_if.rd = 1'b1;
    tick();
    b_if.rd = 1'b0;
    check("fullpop_count", 64'(b_if.ev_count), 64'd2);
    check("fullpop_head",  64'(b_if.ev_value), 64'd2);
    b_if.rd = 1'b1;
    tick();
    b_if.rd = 1'b0;
    check("coal_tail_val",  64'(b_if.ev_value),   64'd4);
    check("coal_tail_ts",   64'(b_if.ev_time),    64'd13);
    check("coal_tail_ch",   64'(b_if.ev_channel), 64'd1);
    check("coal_tail_cnt",  64'(b_if.ev_count),   64'd1);
    b_if.rd = 1'b1;
    tick();
    b_if.rd = 1'b0;
    check("coal_empty",   64'(b_if.ev_valid), 64'd0);
    check("coal_merged2", 64'(b_if.merged),   64'd1);
    b_if.clear = 1'b1;
    tick();
    b_if.clear = 1'b0;
    check("clr2_merged", 64'(b_if.merged), 64'd0);

    // Clear with five queued entries and two pending channels.
    for (int c = 0; c < 5; c++) w = set_ch(w, c, 32'h200 + c);
    a_if.inputs = w; a_if.timestamp = 33'd600; a_if.enable = 1'b1;
    tick();
    a_if.enable = 1'b0;
    repeat (5) tick();
    check("clr_pre_count", 64'(a_if.ev_count), 64'd5);
    w = set_ch(w, 1, 32'h301); w = set_ch(w, 4, 32'h304);
    a_if.inputs = w; a_if.enable = 1'b1;
    tick();
    a_if.enable = 1'b0;
    a_if.clear  = 1'b1;
    a_if.rd     = 1'b1;
    tick();
    a_if.clear  = 1'b0;
    a_if.rd     = 1'b0;
    check("clr_count",  64'(a_if.ev_count), 64'd0);
    check("clr_valid",  64'(a_if.ev_valid), 64'd0);
    check("clr_merged", 64'(a_if.merged),   64'd0);
    tick();
    tick();
    check("clr_nopend", 64'(a_if.ev_valid), 64'd0);
    // After clear the logger must re-prime: this change produces no event.
    w = set_ch(w, 0, 32'h400);
    a_if.inputs = w; a_if.enable = 1'b1;
    tick();
    a_if.enable = 1'b0;
    tick();
    tick();
    check("reprime_valid", 64'(a_if.ev_valid), 64'd0);
    shadow = w;
    rr_m   = 0;
    w = set_ch(w, 1, 32'h501); w = set_ch(w, 4, 32'h504);
    apply_vec(w, 33'd700);
    tick();
    tick();
    check("rr_reset_count", 64'(a_if.ev_count), 64'd2);
    drain("rr_reset");

    // Asynchronous reset between clock edges with an entry queued.
    w = set_ch(w, 0, 32'h600);
    apply_vec(w, 33'd800);
    tick();
    check("arst_pre_count", 64'(a_if.ev_count), 64'd1);
    sb.delete();
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 64'(a_if.ev_valid), 64'd0);
    check("arst_count", 64'(a_if.ev_count), 64'd0);
    check("arst_value", 64'(a_if.ev_value), 64'd0);
    check("arst_time",  64'(a_if.ev_time),  64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
